// File: rtl/sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sweep_ctrl
//   Control stage that sits directly upstream of a BITS-wide loadable up/down
//   counter. It drives the counter's enable/up/load/D inputs and watches the
//   counter's Q to sweep the count back and forth between LO and HI, one step
//   per prescaler tick. It also sequences one-shot loads of a user value and
//   start/stop requests.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      level; in IDLE, begin sweeping
//   stop       in   1      level; return to IDLE (highest priority)
//   dir        in   1      initial direction on start (1 = up, 0 = down)
//   load_req   in   1      request a one-shot load of load_val
//   load_val   in   BITS   value to load into the counter
//   rate       in   DIV_W  counter steps once every rate+1 cycles
//   q_in       in   BITS   counter Q feedback
//   cnt_enable out  1      to counter enable
//   cnt_up     out  1      to counter up
//   cnt_load   out  1      to counter load
//   cnt_d      out  BITS   to counter D (registered copy of load_val)
//   busy       out  1      state != IDLE
//   turn       out  1      1-cycle pulse on a direction-reversing step
//   state_dbg  out  2      current FSM state (0 IDLE, 1 RUN_UP, 2 RUN_DOWN,
//                          3 LOAD) for observation only
// -----------------------------------------------------------------------------
module sweep_ctrl #(
    parameter int unsigned BITS  = 4,
    parameter int unsigned LO    = 0,
    parameter int unsigned HI    = 2**BITS - 1,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load_req,
    input  logic [BITS-1:0]  load_val,
    input  logic [DIV_W-1:0] rate,
    input  logic [BITS-1:0]  q_in,
    output logic             cnt_enable,
    output logic             cnt_up,
    output logic             cnt_load,
    output logic [BITS-1:0]  cnt_d,
    output logic             busy,
    output logic             turn,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_UP   = 2'd1,
        S_RUN_DOWN = 2'd2,
        S_LOAD     = 2'd3
    } state_t;

    localparam logic [BITS-1:0] LO_V = BITS'(LO);
    localparam logic [BITS-1:0] HI_V = BITS'(HI);

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BITS-1:0]   cnt_d_q, cnt_d_d;

    logic run;
    logic tick;
    logic at_hi;
    logic at_lo;

    assign run = (state_q == S_RUN_UP) || (state_q == S_RUN_DOWN);
    // ">=" rather than "==" so that lowering rate below the current div_cnt
    // produces a tick at once instead of waiting for div_cnt to wrap.
    assign tick  = run && (div_cnt_q >= rate);
    // Inclusive bounds: a value loaded outside [LO, HI] is walked back into
    // range by the normal step rules and the counter is never told to wrap.
    assign at_hi = (q_in >= HI_V);
    assign at_lo = (q_in <= LO_V);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            resume_q  <= S_IDLE;
            div_cnt_q <= '0;
            cnt_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            div_cnt_q <= div_cnt_d;
            cnt_d_q   <= cnt_d_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        div_cnt_d  = div_cnt_q;
        cnt_d_d    = cnt_d_q;
        cnt_enable = 1'b0;
        cnt_up     = 1'b0;
        cnt_load   = 1'b0;
        turn       = 1'b0;

        // Counter commands. stop suppresses every command in the same cycle,
        // so neither a step nor a load can slip through on the way to IDLE.
        case (state_q)
            S_RUN_UP: begin
                cnt_enable = tick && !stop;
                cnt_up     = !at_hi;
                turn       = tick && at_hi && !stop;
            end
            S_RUN_DOWN: begin
                cnt_enable = tick && !stop;
                cnt_up     = at_lo;
                turn       = tick && at_lo && !stop;
            end
            S_LOAD: begin
                cnt_enable = !stop;
                cnt_load   = !stop;
            end
            default: begin
            end
        endcase

        // Prescaler only counts while sweeping; parked at 0 otherwise so a
        // fresh run always starts a full rate+1 interval.
        if (run) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end else begin
            div_cnt_d = '0;
        end

        // Request priority: stop > load_req > start.
        if (stop) begin
            state_d   = S_IDLE;
            div_cnt_d = '0;
        end else if (load_req) begin
            cnt_d_d   = load_val;
            // A back-to-back load keeps the original resume target.
            resume_d  = (state_q == S_LOAD) ? resume_q : state_q;
            state_d   = S_LOAD;
            div_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = dir ? S_RUN_UP : S_RUN_DOWN;
                    end
                end
                S_RUN_UP: begin
                    if (tick && at_hi) begin
                        state_d = S_RUN_DOWN;
                    end
                end
                S_RUN_DOWN: begin
                    if (tick && at_lo) begin
                        state_d = S_RUN_UP;
                    end
                end
                S_LOAD: begin
                    state_d = resume_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign cnt_d     = cnt_d_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sweep_ctrl
//   Directed bench for sweep_ctrl with LO=2, HI=5, BITS=4. A behavioural
//   loadable up/down counter closes the loop from cnt_* back to q_in. Every
//   counter action (step or load) is expected in order from a queue of
//   {turn, q_after} entries pushed when the stimulus is set up.
// -----------------------------------------------------------------------------
module tb_sweep_ctrl;

    localparam int BITS  = 4;
    localparam int LO    = 2;
    localparam int HI    = 5;
    localparam int DIV_W = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic             dir;
    logic             load_req;
    logic [BITS-1:0]  load_val;
    logic [DIV_W-1:0] rate;
    logic [BITS-1:0]  q_in;
    logic             cnt_enable;
    logic             cnt_up;
    logic             cnt_load;
    logic [BITS-1:0]  cnt_d;
    logic             busy;
    logic             turn;
    logic [1:0]       state_dbg;

    int checks;
    int errors;

    // {turn during the action, counter value after it}
    logic [BITS:0] exp_q[$];

    sweep_ctrl #(
        .BITS (BITS),
        .LO   (LO),
        .HI   (HI),
        .DIV_W(DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .load_req  (load_req),
        .load_val  (load_val),
        .rate      (rate),
        .q_in      (q_in),
        .cnt_enable(cnt_enable),
        .cnt_up    (cnt_up),
        .cnt_load  (cnt_load),
        .cnt_d     (cnt_d),
        .busy      (busy),
        .turn      (turn),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counter in the loop ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_in <= '0;
        end else if (cnt_load) begin
            q_in <= cnt_d;
        end else if (cnt_enable) begin
            q_in <= cnt_up ? q_in + 4'd1 : q_in - 4'd1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BITS:0] ent(input logic t, input logic [BITS-1:0] q);
        return {t, q};
    endfunction

    // One clock: sample the command for this cycle after inputs settle, then
    // at the next falling edge compare the counter result with the scoreboard.
    task automatic cyc();
        logic          en_s;
        logic          turn_s;
        logic [BITS:0] e;
        #1;
        en_s   = cnt_enable;
        turn_s = turn;
        @(negedge clk);
        if (en_s) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_action observed q=%0d turn=%0d expected none", q_in, turn_s);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_action", {27'd0, turn_s, q_in}, {27'd0, e});
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("sb_drained_left", exp_q.size(), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_from_idle(input logic [BITS-1:0] v);
        exp_q.push_back(ent(1'b0, v));
        load_req = 1'b1;
        load_val = v;
        cyc();
        chk("load_state", state_dbg, 3);
        chk("load_cnt_load", cnt_load, 1);
        chk("load_cnt_enable", cnt_enable, 1);
        chk("load_cnt_up", cnt_up, 0);
        chk("load_cnt_d", cnt_d, v);
        load_req = 1'b0;
        cyc();
        chk("load_back_idle", state_dbg, 0);
    endtask

    task automatic stop_run();
        stop = 1'b1;
        #1;
        chk("stop_gates_enable", cnt_enable, 0);
        cyc();
        chk("stop_busy", busy, 0);
        stop = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int en_cnt;
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        dir      = 1'b0;
        load_req = 1'b0;
        load_val = '0;
        rate     = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_state", state_dbg, 0);
        chk("rst_cnt_enable", cnt_enable, 0);
        chk("rst_cnt_up", cnt_up, 0);
        chk("rst_cnt_load", cnt_load, 0);
        chk("rst_cnt_d", cnt_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_turn", turn, 0);
        reset_n = 1'b1;
        cyc();

        // 1: rate 0 ping-pong from 2, turning at 5 and at 2
        rate = 8'd0;
        load_from_idle(4'd2);
        exp_q.push_back(ent(1'b0, 4'd3));
        exp_q.push_back(ent(1'b0, 4'd4));
        exp_q.push_back(ent(1'b0, 4'd5));
        exp_q.push_back(ent(1'b1, 4'd4));
        exp_q.push_back(ent(1'b0, 4'd3));
        exp_q.push_back(ent(1'b0, 4'd2));
        exp_q.push_back(ent(1'b1, 4'd3));
        start = 1'b1;
        dir   = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_run_up", state_dbg, 1);
        drain(20);
        stop_run();

        // 2: rate 3, one step every 4 cycles
        rate = 8'd3;
        load_from_idle(4'd2);
        exp_q.push_back(ent(1'b0, 4'd3));
        exp_q.push_back(ent(1'b0, 4'd4));
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) chk("t2_tick_pattern", cnt_enable, ((i % 4) == 3) ? 1 : 0);
            if (i == 4) chk("t2_q_at_4", q_in, 3);
            if (i == 8) chk("t2_q_at_8", q_in, 4);
            if (i < 8) cyc();
        end
        chk("t2_sb_left", exp_q.size(), 0);
        stop_run();

        // 3: load 9 while sweeping up at q=4, converge down, bounce at 2
        rate = 8'd0;
        load_from_idle(4'd2);
        exp_q.push_back(ent(1'b0, 4'd3));
        exp_q.push_back(ent(1'b0, 4'd4));
        exp_q.push_back(ent(1'b0, 4'd5));
        exp_q.push_back(ent(1'b0, 4'd9));
        exp_q.push_back(ent(1'b1, 4'd8));
        exp_q.push_back(ent(1'b0, 4'd7));
        exp_q.push_back(ent(1'b0, 4'd6));
        exp_q.push_back(ent(1'b0, 4'd5));
        exp_q.push_back(ent(1'b0, 4'd4));
        exp_q.push_back(ent(1'b0, 4'd3));
        exp_q.push_back(ent(1'b0, 4'd2));
        exp_q.push_back(ent(1'b1, 4'd3));
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("t3_q_before_load", q_in, 4);
        load_req = 1'b1;
        load_val = 4'd9;
        cyc();
        chk("t3_load_state", state_dbg, 3);
        chk("t3_cnt_load", cnt_load, 1);
        chk("t3_cnt_d", cnt_d, 9);
        load_req = 1'b0;
        cyc();
        chk("t3_resume_run_up", state_dbg, 1);
        drain(30);
        stop_run();

        // 4: stop and load_req together mid-run
        load_from_idle(4'd2);
        exp_q.push_back(ent(1'b0, 4'd3));
        exp_q.push_back(ent(1'b0, 4'd4));
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("t4_q_before", q_in, 4);
        stop     = 1'b1;
        load_req = 1'b1;
        load_val = 4'd7;
        #1;
        chk("t4_no_enable", cnt_enable, 0);
        chk("t4_no_load", cnt_load, 0);
        cyc();
        chk("t4_busy", busy, 0);
        chk("t4_state_idle", state_dbg, 0);
        chk("t4_cnt_d_kept", cnt_d, 2);
        stop     = 1'b0;
        load_req = 1'b0;
        cyc();
        chk("t4_q_frozen", q_in, 4);
        chk("t4_sb_left", exp_q.size(), 0);

        // 5: rate 200 -> 1 with div_cnt at 50
        rate = 8'd200;
        load_from_idle(4'd2);
        exp_q.push_back(ent(1'b0, 4'd3));
        exp_q.push_back(ent(1'b0, 4'd4));
        exp_q.push_back(ent(1'b0, 4'd5));
        start = 1'b1;
        cyc();
        start  = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (cnt_enable) en_cnt++;
            cyc();
        end
        chk("t5_no_tick_at_200", en_cnt, 0);
        rate = 8'd1;
        #1;
        chk("t5_tick_now", cnt_enable, 1);
        cyc();
        chk("t5_gap_1", cnt_enable, 0);
        cyc();
        chk("t5_tick_2", cnt_enable, 1);
        cyc();
        chk("t5_gap_2", cnt_enable, 0);
        cyc();
        chk("t5_tick_3", cnt_enable, 1);
        cyc();
        chk("t5_q_final", q_in, 5);
        chk("t5_sb_left", exp_q.size(), 0);
        stop_run();

        // 6: reset asserted during LOAD
        load_req = 1'b1;
        load_val = 4'd6;
        cyc();
        chk("t6_in_load", cnt_load, 1);
        load_req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_cnt_load", cnt_load, 0);
        chk("t6_rst_cnt_enable", cnt_enable, 0);
        chk("t6_rst_cnt_up", cnt_up, 0);
        chk("t6_rst_cnt_d", cnt_d, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_turn", turn, 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("t6_post_state", state_dbg, 0);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_cnt_d", cnt_d, 0);
        chk("t6_post_cnt_enable", cnt_enable, 0);
        chk("t6_sb_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
